// File: rtl/video_timing_pkg.sv
// Shared video timing definitions for the frame-synchronous effect path.
// Contents:
//   SNAP_H_DEFAULT / SNAP_V_DEFAULT  default snapshot position (column 0 of row 721)
//   H_COUNT_W / V_COUNT_W            widths of the raster counters
//   inst_intensity_t                 per-instrument intensity byte {pending, level[6:0]}
//   lane_state_e                     IDLE/PENDING state of one instrument lane
//   decay_level()                    one frame of level fade, used when INST_LEVEL_DECAY_EN is set
package video_timing_pkg;

  localparam int unsigned SNAP_H_DEFAULT = 0;
  localparam int unsigned SNAP_V_DEFAULT = 721;
  localparam int unsigned H_COUNT_W      = 11;
  localparam int unsigned V_COUNT_W      = 10;

  typedef logic [7:0] inst_intensity_t;

  typedef enum logic {StIdle, StPending} lane_state_e;

  // Subtract max(level >> shift, 1), floored at zero, so small levels still reach 0.
  function automatic logic [6:0] decay_level(input logic [6:0] level, input int unsigned shift);
    logic [6:0] dec;
    dec = level >> shift;
    if (dec == 7'd0) dec = 7'd1;
    return (level > dec) ? (level - dec) : 7'd0;
  endfunction

endpackage

// File: rtl/inst_hit_latch_bank_if.sv
// Bus between the trigger front end / raster timing and the hit latch bank.
// Signals:
//   h_count, v_count   current raster position
//   trigger[n]         single-cycle hit pulse per lane
//   velocity[n]        7-bit hit velocity, valid while trigger[n] is high
//   inst_intensity[n]  {pending hit this frame, level[6:0]}
//   snap_strobe        high the cycle after the snapshot cycle
// Modports: master = front end / consumer side, slave = latch bank.
interface inst_hit_latch_bank_if
  import video_timing_pkg::*;
#(
  parameter int unsigned INSTRUMENT_COUNT = 3
);

  logic [H_COUNT_W-1:0]                 h_count;
  logic [V_COUNT_W-1:0]                 v_count;
  logic [INSTRUMENT_COUNT-1:0]          trigger;
  logic [INSTRUMENT_COUNT-1:0][6:0]     velocity;
  inst_intensity_t [INSTRUMENT_COUNT-1:0] inst_intensity;
  logic                                 snap_strobe;

  modport master (
    output h_count, v_count, trigger, velocity,
    input  inst_intensity, snap_strobe
  );

  modport slave (
    input  h_count, v_count, trigger, velocity,
    output inst_intensity, snap_strobe
  );

endinterface

// File: rtl/inst_hit_latch_bank_hit_lane.sv
// One instrument lane: hold-off debounce, IDLE/PENDING state and latched level.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   snap       snapshot cycle, decoded once by the top level
//   trigger    single-cycle hit pulse
//   velocity   7-bit hit velocity
//   intensity  {pending, level[6:0]}, registered
// Optional feature: INST_LEVEL_DECAY_EN makes the level fade per snapshot instead of clearing.
module hit_lane
  import video_timing_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 1024
`ifdef INST_LEVEL_DECAY_EN
  , parameter int unsigned DECAY_SHIFT = 3
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            snap,
  input  logic            trigger,
  input  logic [6:0]      velocity,
  output inst_intensity_t intensity
);

  localparam int unsigned CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES);

  lane_state_e      state_q, state_d;
  logic [6:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      level_q <= 7'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    hit     = trigger && (velocity != 7'd0) && (cnt_q == '0);
    cnt_d   = cnt_q;
    state_d = state_q;
    level_d = level_q;

    // Hold-off runs independently of the frame snapshot.
    if (hit) begin
      cnt_d = HOLDOFF_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (hit) begin
      state_d = StPending;
      // A hit in the snapshot cycle opens the next frame, so it is not max-ed with the old level.
      if (snap || (state_q == StIdle)) begin
        level_d = velocity;
      end else begin
        level_d = (velocity > level_q) ? velocity : level_q;
      end
    end else if (snap) begin
      state_d = StIdle;
`ifdef INST_LEVEL_DECAY_EN
      level_d = decay_level(level_q, DECAY_SHIFT);
`else
      level_d = 7'd0;
`endif
    end
  end

  assign intensity = {(state_q == StPending), level_q};

endmodule

// File: rtl/inst_hit_latch_bank.sv
// Per-instrument hit latch bank feeding the frame-synchronous video effect generators.
// Latches the maximum accepted velocity per frame and releases each hit once at the snapshot
// cycle (h_count == SNAP_H && v_count == SNAP_V). Outputs are registered, so consumers that
// sample inst_intensity during the snapshot cycle see the pre-snapshot value.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   inst_hit_latch_bank_if slave: h_count, v_count, trigger, velocity in;
//         inst_intensity, snap_strobe out
// Optional feature: INST_LEVEL_DECAY_EN enables per-frame level decay by DECAY_SHIFT.
module inst_hit_latch_bank
  import video_timing_pkg::*;
#(
  parameter int unsigned INSTRUMENT_COUNT = 3,
  parameter int unsigned HOLDOFF_CYCLES   = 1024,
  parameter int unsigned SNAP_H           = SNAP_H_DEFAULT,
  parameter int unsigned SNAP_V           = SNAP_V_DEFAULT
`ifdef INST_LEVEL_DECAY_EN
  , parameter int unsigned DECAY_SHIFT    = 3
`endif
) (
  input logic                   clk,
  input logic                   rst,
  inst_hit_latch_bank_if.slave  bus
);

  logic                                   snap;
  logic                                   snap_q;
  inst_intensity_t [INSTRUMENT_COUNT-1:0] lane_intensity;

  assign snap = (bus.h_count == H_COUNT_W'(SNAP_H)) && (bus.v_count == V_COUNT_W'(SNAP_V));

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= 1'b0;
    end else begin
      snap_q <= snap;
    end
  end

  assign bus.snap_strobe = snap_q;

  for (genvar i = 0; i < INSTRUMENT_COUNT; i++) begin : g_lane
    hit_lane #(
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
`ifdef INST_LEVEL_DECAY_EN
      , .DECAY_SHIFT  (DECAY_SHIFT)
`endif
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .snap      (snap),
      .trigger   (bus.trigger[i]),
      .velocity  (bus.velocity[i]),
      .intensity (lane_intensity[i])
    );
  end

  assign bus.inst_intensity = lane_intensity;

endmodule

// File: doc/inst_hit_latch_bank.md
Name: inst_hit_latch_bank

Overview:
- Produces the per-instrument `inst_intensity` bus consumed by the frame-synchronous video effect generators.
- Accepts single-cycle drum trigger pulses with 7-bit velocity and debounces them with a per-instrument hold-off.
- Per video frame, latches the maximum velocity and raises a pending-hit flag in bit 7.
- Releases each hit exactly once, at the frame snapshot point during vertical blanking.
- Sits between the trigger/MIDI front end and the video effect blocks.

Parameters:
- INSTRUMENT_COUNT, 3, number of instrument lanes.
- HOLDOFF_CYCLES, 1024, cycles after an accepted hit during which further triggers on that lane are ignored; 0 disables hold-off.
- SNAP_H, 0, h_count value of the snapshot cycle.
- SNAP_V, 721, v_count value of the snapshot cycle.
- DECAY_SHIFT, 3, per-frame decay shift; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- h_count  in  11  current video column.
- v_count  in  10  current video row.
- trigger[INSTRUMENT_COUNT-1:0]  in  1 each  single-cycle hit pulse per lane.
- velocity[INSTRUMENT_COUNT-1:0]  in  7 each  hit velocity; valid only while trigger is high.
- inst_intensity[INSTRUMENT_COUNT-1:0]  out  8 each  bit 7 = pending hit this frame; bits 6:0 = level.
- snap_strobe  out  1  registered pulse, high the cycle after the snapshot cycle.

Interface decision (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset:
  - All inst_intensity lanes = 8'h00.
  - All hold-off counters = 0.
  - snap_strobe = 0.
  - Reset mid-frame discards pending hits; no snapshot is emitted until the next snapshot cycle.
- Snapshot cycle: `h_count == SNAP_H && v_count == SNAP_V`.
  - Consumers sample inst_intensity combinationally in this cycle, so outputs hold their pre-snapshot value throughout it.
  - All updates caused by the snapshot appear from the next cycle.
- Per-lane state: IDLE (bit7 = 0) or PENDING (bit7 = 1).
- Accepted hit: `trigger && velocity != 0 && holdoff_cnt == 0`.
  - Velocity 0 is always ignored.
  - Hits with holdoff_cnt != 0 are dropped silently.
  - Only accepted hits load the counter.
- Hold-off counter:
  - An accepted hit loads HOLDOFF_CYCLES.
  - Otherwise the counter decrements by 1 per cycle, saturating at 0.
  - The counter is independent of the snapshot.
- IDLE + accepted hit: level <= velocity, bit7 <= 1, go to PENDING. Latency is 1 cycle (visible at t+1).
- PENDING + accepted hit: level <= max(level, velocity); bit7 stays 1.
- Snapshot with no hit in the same cycle:
  - bit7 <= 0, go to IDLE.
  - Level handling per the optional feature.
- Accepted hit in the snapshot cycle:
  - The hit belongs to the next frame.
  - Result: bit7 <= 1, level <= velocity (not max-ed with the old level).
- Lanes are fully independent; simultaneous triggers on all lanes are all accepted.
- snap_strobe <= (snapshot cycle), registered.
- Widths:
  - Hold-off counter is $clog2(HOLDOFF_CYCLES+1) bits, minimum 1.
  - Level arithmetic is 7 bits unsigned with no overflow possible.

Optional Feature:
- Macro: INST_LEVEL_DECAY_EN.
- Defined: on each snapshot where no hit is accepted, level <= level − max(level >> DECAY_SHIFT, 1), saturating at 0. Bits 6:0 therefore give a fading glow while bit7 = 0.
- Undefined: level <= 0 at the snapshot. inst_intensity is 8'h00 whenever bit7 = 0.

Decomposition:
- Shared package `video_timing_pkg`:
  - localparams SNAP_H_DEFAULT = 0 and SNAP_V_DEFAULT = 721.
  - H_COUNT_W = 11, V_COUNT_W = 10.
  - typedef inst_intensity_t (logic [7:0]) for reuse by the effect generators.
- One sub-module, `hit_lane`: one lane (hold-off counter, IDLE/PENDING state, level register, decay). It is instantiated INSTRUMENT_COUNT times in a generate loop.
- The top level decodes the snapshot cycle once and fans it out to all lanes.

Test Plan:
- Reset:
  - Stimulus: assert rst with a lane PENDING at velocity 7'h50.
  - Required: all lanes read 8'h00 the next cycle and snap_strobe = 0.
- Basic hit and release:
  - Stimulus: trigger lane 0 with velocity 7'h40 at mid-frame.
  - Required: 8'hC0 from the next cycle through the snapshot cycle inclusive; 8'h00 after it (decay off), or 8'h38 (decay on, 0x40 − 8).
- Max and hold-off:
  - Stimulus: HOLDOFF_CYCLES = 4; hits 7'h20 at t0, 7'h70 at t0+2, 7'h60 at t0+5.
  - Required: the t0+2 hit is dropped; the t0+5 hit is accepted; output is 8'hE0.
- Snapshot collision:
  - Stimulus: lane 1 PENDING at 7'h30; a hit of 7'h10 arrives in the snapshot cycle.
  - Required: the snapshot cycle shows 8'hB0; the next cycle shows 8'h90.
- Velocity 0 and lane independence:
  - Stimulus: lane 2 trigger with velocity 0, simultaneous with lane 0 trigger at 7'h7F.
  - Required: lane 2 stays 8'h00 with no hold-off started; lane 0 = 8'hFF.
- Decay to zero (INST_LEVEL_DECAY_EN):
  - Stimulus: a single hit of 7'h03, then let frames pass with no hits.
  - Required: levels 3 → 2 → 1 → 0 on successive snapshots, then hold at 0.
